// File: rtl/readout_pkg.sv
// Shared definitions for the pixel readout path: FSM encoding, width helper
// and the default readout data width.
package readout_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin search: first set request at or after ptr, wrapping modulo N_REQ.
module rr_priority_pick
  import readout_pkg::*;
#(
  parameter int N_REQ  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              found,
  output logic [ADDR_W-1:0] g
);

  logic [ADDR_W:0] idx;

  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + (ADDR_W+1)'(i);
      if (idx >= (ADDR_W+1)'(N_REQ)) idx = idx - (ADDR_W+1)'(N_REQ);
      if (!found && req[idx[ADDR_W-1:0]]) begin
        found = 1'b1;
        g     = idx[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pixel_readout_arbiter.sv
// Round-robin req/ack arbiter for a shared pixel column bus with a single-entry
// valid/ready output register and a sticky release-timeout flag.
module pixel_readout_arbiter
  import readout_pkg::*;
#(
  parameter  int N_REQ   = 8,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int TIMEOUT = 15,
  localparam int ADDR_W  = clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  ack,
  input  logic [DATA_W-1:0] pix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err_timeout,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  // Handshake: a word moves downstream on any edge where out_valid && out_ready.
  state_t            state_q, state_n;
  logic [ADDR_W-1:0] ptr_q, g_q, pick_g, ptr_next;
  logic [CNT_W-1:0]  cnt_q;
  logic              pick_found, slot_free;
  logic              start, capture, release_done, tmo;

  rr_priority_pick #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .g     (pick_g)
  );

  assign ptr_next  = (g_q == ADDR_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_n      = state_q;
    start        = 1'b0;
    capture      = 1'b0;
    release_done = 1'b0;
    tmo          = 1'b0;
    slot_free    = !out_valid || out_ready;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_found && slot_free) begin
          start   = 1'b1;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        capture = 1'b1;
        state_n = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!req[g_q]) begin
          release_done = 1'b1;
          state_n      = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th one spent waiting for the drop.
          release_done = 1'b1;
          tmo          = 1'b1;
          state_n      = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ack         <= '0;
      ptr_q       <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_n;
      if (start) begin
        ack <= ONE << pick_g;
        g_q <= pick_g;
      end
      if (release_done) begin
        ack   <= '0;
        ptr_q <= ptr_next;
        cnt_q <= '0;
      end else if (state_q == ST_RELEASE) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tmo) err_timeout <= 1'b1;
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= pix_data;
        out_addr  <= g_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_readout_arbiter.sv
// Bench for pixel_readout_arbiter: scenario tasks plus a scoreboard of
// expected {addr,data} words checked on every output handshake.
module tb_pixel_readout_arbiter;

  localparam int N_REQ   = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;
  localparam int ADDR_W  = 3;

  logic              clk = 1'b0;
  logic              rst, enable, out_ready;
  logic              out_valid, busy, err_timeout;
  logic [N_REQ-1:0]  req, ack;
  logic [DATA_W-1:0] pix_data, out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0]        pixel_val [N_REQ];
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] mon_w;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pixel_readout_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .ack         (ack),
    .pix_data    (pix_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .busy        (busy),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pixel bus model: the acked pixel drives its value
  always_comb begin
    pix_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (ack[i]) pix_data = pixel_val[i];
  end

  // scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word_unexpected: got addr=%0d data=%h, want no word", out_addr, out_data);
      end else begin
        mon_w = exp_q.pop_front();
        if ({out_addr, out_data} !== mon_w) begin
          bad++;
          $display("FAIL word: got addr=%0d data=%h, want addr=%0d data=%h",
                   out_addr, out_data, mon_w[ADDR_W+DATA_W-1:DATA_W], mon_w[DATA_W-1:0]);
        end
      end
    end
  end

  function automatic logic [N_REQ-1:0] oh(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; enable = 1'b1; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_word(input int i);
    exp_q.push_back({ADDR_W'(i), pixel_val[i]});
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 12);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N_REQ; i++) pixel_val[i] = DATA_W'($urandom_range(0, 255));
    reset_dut();
    total++; if (ack !== '0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", out_addr); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_single();
    int n;
    pixel_val[3] = 8'hA5;
    out_ready = 1'b0;
    req = 8'h08;
    push_word(3);
    tick();
    total++; if (ack !== 8'h08) begin bad++; $display("FAIL single_ack1: got %b want 00001000", ack); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency: got valid=%b want 0", out_valid); end
    tick();
    req = 8'h00;
    total++; if (ack !== 8'h08) begin bad++; $display("FAIL single_ack2: got %b want 00001000", ack); end
    total++; if (out_valid !== 1'b1 || out_addr !== 3'd3 || out_data !== 8'hA5) begin
      bad++; $display("FAIL single_word: got v=%b a=%0d d=%h want v=1 a=3 d=a5", out_valid, out_addr, out_data);
    end
    tick();
    total++; if (ack !== '0 || busy !== 1'b0) begin bad++; $display("FAIL single_release: got ack=%b busy=%b want 0 0", ack, busy); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got valid=%b want 0", out_valid); end
    // pointer now 4: of pixels 3 and 4, pixel 4 must win
    req = 8'h18;
    push_word(4);
    wait_ack(n);
    req = 8'h00;
    total++; if (ack !== 8'h10) begin bad++; $display("FAIL single_ptr: got %b want 00010000", ack); end
    repeat (4) tick();
  endtask

  task automatic test_fairness();
    int n, idx, prev_cyc;
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) pixel_val[i] = DATA_W'($urandom_range(0, 255));
    req = '1;
    prev_cyc = 0;
    for (int k = 0; k <= N_REQ; k++) begin
      idx = k % N_REQ;
      push_word(idx);
      wait_ack(n);
      total++; if (ack !== oh(idx)) begin bad++; $display("FAIL fair_order k=%0d: got %b want %b", k, ack, oh(idx)); end
      if (k > 0) begin
        total++; if (cyc - prev_cyc !== 3) begin bad++; $display("FAIL fair_rate k=%0d: got %0d cycles want 3", k, cyc - prev_cyc); end
      end
      prev_cyc = cyc;
      req[idx] = 1'b0;
      tick(); tick();
      req[idx] = 1'b1;
    end
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_back_pressure();
    int n;
    reset_dut();
    pixel_val[1] = DATA_W'($urandom_range(0, 255));
    pixel_val[2] = DATA_W'($urandom_range(0, 255));
    req = 8'h02;
    push_word(1);
    wait_ack(n);
    total++; if (ack !== 8'h02) begin bad++; $display("FAIL bp_ack1: got %b want 00000010", ack); end
    req = 8'h00;
    tick();
    req = 8'h04;
    push_word(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (ack !== '0 || out_valid !== 1'b1 || out_addr !== 3'd1 || out_data !== pixel_val[1]) begin
        bad++; $display("FAIL bp_hold %0d: got ack=%b v=%b a=%0d d=%h want ack=0 v=1 a=1 d=%h",
                        i, ack, out_valid, out_addr, out_data, pixel_val[1]);
      end
    end
    out_ready = 1'b1;
    tick();
    total++; if (ack !== 8'h04) begin bad++; $display("FAIL bp_ack2: got %b want 00000100", ack); end
    req = 8'h00;
    repeat (4) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_timeout();
    int n;
    reset_dut();
    out_ready = 1'b1;
    pixel_val[5] = DATA_W'($urandom_range(0, 255));
    pixel_val[6] = DATA_W'($urandom_range(0, 255));
    req = 8'h20;
    push_word(5);
    wait_ack(n);
    total++; if (ack !== 8'h20) begin bad++; $display("FAIL tmo_ack: got %b want 00100000", ack); end
    n = 0;
    while (ack === 8'h20 && n < 40) begin
      tick();
      n++;
      if (n == 3) begin
        req[6] = 1'b1;
        push_word(6);
      end
    end
    total++; if (n !== TIMEOUT + 1) begin bad++; $display("FAIL tmo_len: got ack high %0d cycles want %0d", n, TIMEOUT + 1); end
    total++; if (err_timeout !== 1'b1 || ack !== '0) begin bad++; $display("FAIL tmo_flag: got err=%b ack=%b want 1 0", err_timeout, ack); end
    tick();
    total++; if (ack !== 8'h40) begin bad++; $display("FAIL tmo_next: got %b want 01000000", ack); end
    req = 8'h00;
    repeat (4) tick();
    total++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL tmo_sticky: got err=%b busy=%b want 1 0", err_timeout, busy); end
  endtask

  task automatic test_reset_midop();
    int n;
    out_ready = 1'b0;
    pixel_val[2] = DATA_W'($urandom_range(0, 255));
    req = 8'h04;
    push_word(2);
    wait_ack(n);
    tick(); tick();
    total++; if (ack !== 8'h04 || dbg_state !== 2'd2) begin bad++; $display("FAIL mid_pre: got ack=%b st=%0d want 00000100 2", ack, dbg_state); end
    rst = 1'b1;
    tick();
    total++; if (ack !== '0 || out_valid !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      bad++; $display("FAIL mid_reset: got ack=%b v=%b err=%b busy=%b d=%h want all 0", ack, out_valid, err_timeout, busy, out_data);
    end
    exp_q.delete();
    rst = 1'b0;
    pixel_val[0] = DATA_W'($urandom_range(0, 255));
    req = 8'h81;
    push_word(0);
    wait_ack(n);
    total++; if (ack !== 8'h01) begin bad++; $display("FAIL mid_ptr: got %b want 00000001", ack); end
    req = 8'h00;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_enable();
    int n;
    pixel_val[4] = DATA_W'($urandom_range(0, 255));
    enable = 1'b0;
    req = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ack !== '0 || busy !== 1'b0) begin bad++; $display("FAIL en_gate %0d: got ack=%b busy=%b want 0 0", i, ack, busy); end
    end
    enable = 1'b1;
    push_word(4);
    tick();
    total++; if (ack !== 8'h10) begin bad++; $display("FAIL en_grant: got %b want 00010000", ack); end
    req = 8'h00;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; req = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_timeout();
    test_reset_midop();
    test_enable();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_words: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_readout_arbiter.md
Name: pixel_readout_arbiter

Overview:
Synchronous round-robin arbiter that shares one column readout bus among N_REQ pixel requesters using a 4-phase req/ack handshake. The granted pixel drives pix_data while its ack is high. The arbiter captures the word and its pixel address into a single-entry output register, which a valid/ready interface drains toward the readout serializer. The arbiter also detects pixels that never release their request.

Parameters:
N_REQ, 8, number of requesting pixels (>=2)
DATA_W, 8, width of the shared pixel data bus
TIMEOUT, 15, cycles allowed in RELEASE for the granted req to drop (>=1)
ADDR_W, $clog2(N_REQ), derived localparam, not overridable

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  when 0, no new grants are issued; a transaction in progress completes
req  input  N_REQ  level request per pixel, held until ack is seen
ack  output  N_REQ  one-hot or zero grant, registered
pix_data  input  DATA_W  shared bus, valid during GRANT
out_valid  output  1  output word available
out_ready  input  1  downstream accepts the word
out_addr  output  ADDR_W  index of the pixel that produced out_data
out_data  output  DATA_W  captured pixel word
busy  output  1  high whenever state != IDLE
err_timeout  output  1  sticky; set on a release timeout, cleared only by rst

Behaviour:
- Reset (synchronous, rst=1 at an edge): ack=0, out_valid=0, out_addr=0, out_data=0, busy=0, err_timeout=0, round-robin pointer ptr=0, timeout counter=0, state=IDLE. Reset mid-transaction drops ack at that same edge and discards any captured word.
- States: IDLE, GRANT, RELEASE.
- IDLE to GRANT: requires enable=1, |req=1, and a free output slot (out_valid=0, or out_valid=1 with out_ready=1 in the same cycle).
  - Winner g is the first set req index at or after ptr, searching upward and wrapping modulo N_REQ.
  - At the edge: ack[g]<=1, latch g.
- GRANT: lasts exactly 1 cycle.
  - At its closing edge: out_data<=pix_data, out_addr<=g, out_valid<=1, state=RELEASE.
  - ack[g] stays high.
  - req[g] is not checked in GRANT.
- RELEASE:
  - If req[g]=0: ack<=0, ptr<=(g+1) mod N_REQ, counter<=0, state=IDLE.
  - Else counter increments. When counter reaches TIMEOUT with req[g] still 1: ack<=0, err_timeout<=1, ptr<=(g+1) mod N_REQ, counter<=0, state=IDLE.
- Output handshake:
  - out_valid clears on an edge where out_valid=1 and out_ready=1, unless a GRANT capture happens on the same edge; in that case the new word is loaded and out_valid stays 1.
  - out_addr and out_data are stable while out_valid=1 and out_ready=0.
- Latency: req sampled high in IDLE -> ack at +1 edge -> out_valid at +2 edges.
- Throughput: at most 1 word per 3 cycles.
- At most one ack bit is high at any time. ack is 0 in IDLE.
- A req deasserting before its grant is simply ignored; the arbiter never needs to withdraw a grant.
- Back-pressure: with out_valid=1 and out_ready=0, IDLE holds even when requests are pending.
- enable falling during GRANT or RELEASE does not abort the transaction.
- Pointer wrap: g=N_REQ-1 sets ptr to 0.
- A timed-out pixel that keeps its req asserted is eligible again only after every other requester in round-robin order.

Decomposition:
- Shared package readout_pkg: state encodings (IDLE/GRANT/RELEASE localparams), a clog2 function, and the common readout widths (DATA_W default).
- One sub-module, rr_priority_pick: combinational; inputs req and ptr; outputs a found flag and the winner index g.
- FSM, counter and output register stay in the top.

Test Plan:
- Single requester: N_REQ=8, req[3]=1 and pix_data=0xA5; req[3] drops 1 cycle after ack -> ack[3] high for 2 cycles, out_valid=1 with out_addr=3 and out_data=0xA5, ptr=4.
- Fairness: req=0xFF held continuously, out_ready=1, each pixel drops its req after ack and re-raises 1 cycle later -> grant order 0,1,...,7,0 with 3 cycles per word.
- Back-pressure: out_ready=0, req[1] then req[2] -> word from pixel 1 held stable, no ack[2] until out_ready=1; on that same edge the slot is freed and ack[2] rises.
- Timeout: TIMEOUT=15, req[5] held high forever -> ack[5] drops 15 cycles into RELEASE, err_timeout=1 and stays 1; with req[6]=1 also asserted, the next grant goes to 6.
- Reset mid-op: assert rst during RELEASE with ack[2]=1 -> next edge ack=0, out_valid=0, err_timeout=0, ptr=0, busy=0.
- Enable gating: enable=0 with req=0x10 -> no ack, busy=0; enable=1 -> ack[4] at +1 edge.
